// File: rtl/hazard_controller.sv
// Hazard controller for a five-stage pipeline. It shadows the EX, MEM and WB
// stages, detects load-use and flag hazards against the instruction in ID,
// issues stall/flush control and selects EX operand forwarding.
module hazard_controller #(
    parameter int REG_ZERO = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_r2,
    input  logic             id_uses_rn,
    input  logic             id_uses_r2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_load,
    input  logic             id_flag_en,
    input  logic             id_uses_flags,
    input  logic             ex_br_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [4:0] ZERO_REG = 5'(REG_ZERO);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Full record for the EX stage: its sources drive forwarding and its
    // load/flag bits drive hazard detection.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       load;
        logic       flag_en;
        logic [4:0] rn;
        logic [4:0] r2;
        logic       uses_rn;
        logic       uses_r2;
    } ex_rec_t;

    // MEM and WB only ever act as forwarding sources, so only their
    // write-back fields carry any observable information.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } wr_rec_t;

    ex_rec_t ex_r;
    wr_rec_t mem_r;
    wr_rec_t wb_r;

    logic load_use_s;
    logic flag_haz_s;
    logic stall_s;
    logic bubble_s;

    // True when a stage record writes architectural register r.
    function automatic logic writes_reg(input logic valid, input logic reg_write,
                                        input logic [4:0] rd, input logic [4:0] r);
        return valid & reg_write & (rd == r) & (r != ZERO_REG);
    endfunction

    // Operand select: MEM result beats WB data, otherwise the register file.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] r,
                                           input wr_rec_t mem, input wr_rec_t wb);
        logic [1:0] sel;
        if (uses && writes_reg(mem.valid, mem.reg_write, mem.rd, r)) begin
            sel = 2'b01;
        end else if (uses && writes_reg(wb.valid, wb.reg_write, wb.rd, r)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection against the instruction currently in ID.
    always_comb begin
        load_use_s = id_valid & ex_r.valid & ex_r.load &
                     ((id_uses_rn & writes_reg(ex_r.valid, ex_r.reg_write, ex_r.rd, id_rn)) |
                      (id_uses_r2 & writes_reg(ex_r.valid, ex_r.reg_write, ex_r.rd, id_r2)));
        flag_haz_s = id_valid & id_uses_flags & ex_r.valid & ex_r.flag_en;
        stall_s    = (load_use_s | flag_haz_s) & ~ex_br_taken;
        bubble_s   = stall_s | ex_br_taken;
    end

    // Pipeline control and forwarding; forced to idle values while in reset.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        fwd_a         = 2'b00;
        fwd_b         = 2'b00;
        if (!reset) begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
        end else begin
            fwd_a = fwd_sel(ex_r.uses_rn, ex_r.rn, mem_r, wb_r);
            fwd_b = fwd_sel(ex_r.uses_r2, ex_r.r2, mem_r, wb_r);
            if (ex_br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall_s) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
            end else begin
                idex_bubble = 1'b0;
            end
        end
    end

    // Shadow pipeline advance; a bubble enters EX on stall or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            wb_r  <= mem_r;
            mem_r <= '{valid: ex_r.valid, rd: ex_r.rd, reg_write: ex_r.reg_write};
            ex_r  <= '{valid: id_valid & ~bubble_s, rd: id_rd, reg_write: id_reg_write,
                       load: id_load, flag_en: id_flag_en, rn: id_rn, r2: id_r2,
                       uses_rn: id_uses_rn, uses_r2: id_uses_r2};
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_s && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (ex_br_taken && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule
